ota_bitstream_decimator: RTL and testbench

// - Downstream consumer of the digital OTA comparator output (1-bit, pad-level, asynchronous to clk).
// - Synchronises the bit, then counts ones over a fixed window of 2^WIN_LOG2 clocks.
// - Emits one OUT_W-bit duty-cycle code per window on a valid/ready handshake.
// - Feeds uo_out / the host readout path of the top level.

---
 rtl/ota_bitstream_decimator.sv | 170 +++++++++++++++++
 tb/tb_ota_bitstream_decimator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ota_bitstream_decimator.sv
// ota_bitstream_decimator
//   Takes the 1-bit OTA comparator output, which is asynchronous to clk, and
//   synchronises it. It counts ones over back-to-back windows of 2^WIN_LOG2
//   clocks. Each window produces one OUT_W-bit duty-cycle code, which is
//   offered to the consumer on a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         run enable (level); dropping it aborts the current window
//   ota_in     comparator output (pad pulled low, so high-Z reads as 0)
//   ready_i    consumer accepts sample_o when valid_o && ready_i
//   sample_o   scaled ones-count of the last completed window
//   valid_o    sample_o holds an unconsumed result
//   ovf_o      sticky: a result was overwritten before being consumed
//   busy_o     high while settling or accumulating
//   toggles_o  s_bit transition count of the last window (0 when not built)
//
// Build option
//   OTA_DEC_TOGGLE_CNT_EN  builds the per-window transition counter behind
//                          toggles_o. Without it, toggles_o is tied to 0.
//
// State table
//   state     | meaning
//   ST_IDLE   | stopped; waiting for en
//   ST_SETTLE | flushing SYNC_STAGES cycles of stale synchroniser data
//   ST_ACCUM  | counting ones; a window closes every 2^WIN_LOG2 cycles
module ota_bitstream_decimator #(
  parameter int WIN_LOG2    = 8,
  parameter int OUT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ota_in,
  input  logic             ready_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o,
  output logic [7:0]       toggles_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACCUM} state_t;

  localparam logic [2:0]          SETTLE_LOAD = 3'(SYNC_STAGES - 1);
  localparam logic [WIN_LOG2-1:0] WIN_ONE     = 1;
  localparam int                  SHIFT       = WIN_LOG2 - OUT_W;

  state_t              state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s_bit;
  logic [2:0]          settle_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                primed;
  logic [WIN_LOG2:0]   ones_cnt;
  logic [OUT_W-1:0]    code;
  logic                close_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ota_in};
  end

  assign s_bit = sync_q[SYNC_STAGES-1];

  // primed masks the first ACCUM cycle. At that point win_cnt is 0, but no
  // samples have been collected yet. The wrap back to 0 marks a full window.
  assign close_win = (state == ST_ACCUM) && en && primed && (win_cnt == '0);

  // All-ones is the only count that needs bit WIN_LOG2. It saturates instead
  // of wrapping to zero.
  always_comb begin
    code = '0;
    if (ones_cnt[WIN_LOG2]) code = '1;
    else                    code = OUT_W'(ones_cnt >> SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      primed     <= 1'b0;
      ones_cnt   <= '0;
      sample_o   <= '0;
      valid_o    <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state      <= ST_SETTLE;
            busy_o     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            win_cnt    <= '0;
            primed     <= 1'b0;
            ones_cnt   <= '0;
            ovf_o      <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!en) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= ST_ACCUM;
          end else begin
            settle_cnt <= settle_cnt - 3'd1;
          end
        end
        ST_ACCUM: begin
          if (!en) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            win_cnt <= win_cnt + WIN_ONE;
            primed  <= 1'b1;
            // On the closing cycle, the current sample opens the next window.
            if (close_win) ones_cnt <= {{WIN_LOG2{1'b0}}, s_bit};
            else           ones_cnt <= ones_cnt + {{WIN_LOG2{1'b0}}, s_bit};
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase

      if (close_win) begin
        sample_o <= code;
        valid_o  <= 1'b1;
        if (valid_o && !ready_i) ovf_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef OTA_DEC_TOGGLE_CNT_EN
  logic       prev_s;
  logic [7:0] tog_cnt;

  // The transition between the closing sample and the one before it falls
  // between two windows, so it is not counted in either window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_s    <= 1'b0;
      tog_cnt   <= '0;
      toggles_o <= '0;
    end else begin
      prev_s <= s_bit;
      if (state == ST_IDLE) begin
        tog_cnt <= '0;
      end else if (close_win) begin
        toggles_o <= tog_cnt;
        tog_cnt   <= '0;
      end else if (state == ST_ACCUM && en && primed && (s_bit != prev_s)
                   && (tog_cnt != 8'hFF)) begin
        tog_cnt <= tog_cnt + 8'd1;
      end
    end
  end
`else
  assign toggles_o = 8'h00;
`endif

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
module tb_ota_bitstream_decimator;

  typedef struct {
    int code;
    int tog;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en4, ota4, ready4, valid4, ovf4, busy4;
  logic [3:0] sample4;
  logic [7:0] tog4;
  logic       en8, ota8, ready8, valid8, ovf8, busy8;
  logic [7:0] sample8;
  logic [7:0] tog8;

  int   n_checks = 0;
  int   n_errors = 0;
  int   last_code4 = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  always #5 clk = ~clk;

  ota_bitstream_decimator #(.WIN_LOG2(4), .OUT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .ota_in(ota4), .ready_i(ready4),
    .sample_o(sample4), .valid_o(valid4), .ovf_o(ovf4), .busy_o(busy4),
    .toggles_o(tog4)
  );

  ota_bitstream_decimator #(.WIN_LOG2(8), .OUT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .ota_in(ota8), .ready_i(ready8),
    .sample_o(sample8), .valid_o(valid8), .ovf_o(ovf8), .busy_o(busy8),
    .toggles_o(tog8)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted transfer must match the next expected result.
  always @(negedge clk) begin
    if (!rst && valid4 && ready4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut4_unexpected: got sample %0d expected no transfer", sample4);
      end else begin
        e4 = q4.pop_front();
        check("dut4_sample", sample4, e4.code);
        check("dut4_toggles", tog4, e4.tog);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid8 && ready8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut8_unexpected: got sample %0d expected no transfer", sample8);
      end else begin
        e8 = q8.pop_front();
        check("dut8_sample", sample8, e8.code);
        check("dut8_toggles", tog8, e8.tog);
      end
    end
  end

  function automatic bit gen(input int mode, input int k);
    case (mode)
      0:       return 1'($urandom_range(0, 1));
      1:       return (k % 16) < 10;
      2:       return 1'b1;
      4:       return 1'(k % 2);
      default: return 1'b0;
    endcase
  endfunction

  // Drives one enabled run of nwin windows. vals[k] is the input value sampled
  // on edge k, where edge 0 is the edge that sees en=1. Window n covers the
  // samples on edges 1+len*n .. len+len*n: two synchroniser stages, then two
  // settle cycles. push: 0 none, 1 last window only, 2 every window.
  task automatic run_stream(input bit big, input int nwin, input int mode,
                            input int push, output int first_valid);
    int   wl, len, ncyc, ones, tg;
    bit   vals[$];
    exp_t e;
    wl   = big ? 8 : 4;
    len  = 1 << wl;
    ncyc = len * nwin + 3;
    for (int k = 0; k <= ncyc; k++) vals.push_back(gen(mode, k));
    for (int n = 0; n < nwin; n++) begin
      ones = 0;
      tg   = 0;
      for (int i = 0; i < len; i++) begin
        ones += int'(vals[1 + len*n + i]);
        if (i > 0 && vals[1 + len*n + i] != vals[len*n + i]) tg++;
      end
      e.code = (ones == len) ? len - 1 : ones;
`ifdef OTA_DEC_TOGGLE_CNT_EN
      e.tog = (tg > 255) ? 255 : tg;
`else
      e.tog = 0;
`endif
      if (push == 2 || (push == 1 && n == nwin - 1)) begin
        if (big) q8.push_back(e);
        else     q4.push_back(e);
      end
      if (!big) last_code4 = e.code;
    end
    first_valid = -1;
    for (int k = 0; k <= ncyc; k++) begin
      if (big) begin en8 = 1'b1; ota8 = vals[k]; end
      else     begin en4 = 1'b1; ota4 = vals[k]; end
      tick();
      if ((big ? valid8 : valid4) && first_valid < 0) first_valid = k;
    end
    if (big) begin en8 = 1'b0; ota8 = 1'b0; end
    else     begin en4 = 1'b0; ota4 = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  fv;
    bit  saw_valid;
    rst = 1'b1;
    en4 = 0; ota4 = 0; ready4 = 0;
    en8 = 0; ota8 = 0; ready8 = 0;
    repeat (3) tick();
    check("rst_sample", sample4, 0);
    check("rst_valid", valid4, 0);
    check("rst_ovf", ovf4, 0);
    check("rst_busy", busy4, 0);
    check("rst_toggles", tog4, 0);
    rst = 1'b0;

    // Idle with a toggling input: nothing may happen.
    saw_valid = 0;
    for (int k = 0; k < 40; k++) begin
      ota4 = ~ota4;
      tick();
      saw_valid |= valid4 | busy4;
    end
    check("idle_no_activity", saw_valid, 0);
    check("idle_sample", sample4, 0);

    // Duty 10/16, phase-locked, back-to-back windows.
    ready4 = 1'b1;
    run_stream(0, 3, 1, 2, fv);
    check("duty_first_valid_edge", fv, 19);
    repeat (3) tick();
    check("duty_drained", q4.size(), 0);

    run_stream(0, 4, 0, 2, fv);
    repeat (3) tick();
    run_stream(0, 1, 2, 2, fv);
    repeat (3) tick();
    run_stream(0, 1, 3, 2, fv);
    repeat (3) tick();
    run_stream(0, 1, 4, 2, fv);
    repeat (3) tick();
    check("patterns_drained", q4.size(), 0);

    // Backpressure across two closes: only the second result is delivered.
    ready4 = 1'b0;
    run_stream(0, 2, 0, 1, fv);
    check("bp_valid_held", valid4, 1);
    check("bp_ovf_set", ovf4, 1);
    ready4 = 1'b1;
    tick();
    check("bp_valid_drop", valid4, 0);
    check("bp_ovf_sticky", ovf4, 1);
    en4 = 1'b1;
    tick();
    check("bp_ovf_clear_on_start", ovf4, 0);
    en4 = 1'b0;
    repeat (3) tick();
    check("bp_drained", q4.size(), 0);

    // Abort at ACCUM cycle 7: no result, outputs hold.
    for (int k = 0; k < 10; k++) begin
      en4 = 1'b1; ota4 = 1'b1;
      tick();
    end
    en4 = 1'b0;
    tick();
    check("abort_busy_low", busy4, 0);
    repeat (30) tick();
    check("abort_no_valid", valid4, 0);
    check("abort_sample_hold", sample4, last_code4);

    // Reset during a window clears the outputs asynchronously.
    ready4 = 1'b0;
    run_stream(0, 1, 2, 0, fv);
    check("prerst_sample", sample4, 15);
    repeat (8) begin
      en4 = 1'b1;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("arst_sample", sample4, 0);
    check("arst_valid", valid4, 0);
    check("arst_busy", busy4, 0);
    #1 rst = 1'b0;
    en4 = 1'b0;
    ready4 = 1'b1;
    repeat (3) tick();

    // Wide configuration: 256-cycle windows.
    ready8 = 1'b1;
    run_stream(1, 1, 2, 2, fv);
    check("w8_first_valid_edge", fv, 259);
    repeat (3) tick();
    run_stream(1, 1, 4, 2, fv);
    repeat (3) tick();
    run_stream(1, 1, 0, 2, fv);
    repeat (3) tick();
    check("w8_drained", q8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
